// File: rtl/ex_pipe_ctrl_pkg.sv
// rtl/ex_pipe_ctrl_pkg.sv - shared types and constants for the EX pipeline control unit
//
// Purpose : mul/div sequencing state encoding, register index width and the
//           default redirect PC width taken from the core-wide `PC_WIDTH define.
// Ports   : none (package)

`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif

package ex_pipe_ctrl_pkg;

  localparam int PC_WIDTH_DEF = `PC_WIDTH;
  localparam int REG_IDX_W    = 5;

  // RUN     : no mul/div outstanding
  // MD_BUSY : start issued, waiting for md_done_i
  // MD_DONE : result available but MEM is holding the pipe
  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MD_BUSY = 2'd1,
    ST_MD_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/ex_pipe_ctrl_if.sv
// rtl/ex_pipe_ctrl_if.sv - hazard/stall signal bundle between pipeline stages and the control unit
//
// Purpose : groups the EX/ID hazard inputs, the mul/div handshake, the MEM
//           ready and the per-stage stall/flush/redirect outputs.
// Modports: slave  - control unit side (consumes stage status, drives controls)
//           master - pipeline side (drives stage status, consumes controls)

interface ex_pipe_ctrl_if
  import ex_pipe_ctrl_pkg::*;
#(
  parameter int PC_WIDTH = PC_WIDTH_DEF
) ();

  logic                 ex_valid_i;
  logic                 ex_jump_i;
  logic [PC_WIDTH-1:0]  ex_jump_pc_i;
  logic                 ex_is_load_i;
  logic                 ex_rd_wen_i;
  logic [REG_IDX_W-1:0] ex_rd_idx_i;
  logic                 ex_md_op_i;
  logic                 id_valid_i;
  logic                 id_rs1_ren_i;
  logic                 id_rs2_ren_i;
  logic [REG_IDX_W-1:0] id_rs1_idx_i;
  logic [REG_IDX_W-1:0] id_rs2_idx_i;
  logic                 md_start_o;
  logic                 md_done_i;
  logic                 mem_ready_i;
  logic                 if_stall_o;
  logic                 id_stall_o;
  logic                 ex_stall_o;
  logic                 id_flush_o;
  logic                 ex_flush_o;
  logic                 redirect_o;
  logic [PC_WIDTH-1:0]  redirect_pc_o;

  modport slave (
    input  ex_valid_i, ex_jump_i, ex_jump_pc_i, ex_is_load_i, ex_rd_wen_i,
           ex_rd_idx_i, ex_md_op_i, id_valid_i, id_rs1_ren_i, id_rs2_ren_i,
           id_rs1_idx_i, id_rs2_idx_i, md_done_i, mem_ready_i,
    output md_start_o, if_stall_o, id_stall_o, ex_stall_o, id_flush_o,
           ex_flush_o, redirect_o, redirect_pc_o
  );

  modport master (
    output ex_valid_i, ex_jump_i, ex_jump_pc_i, ex_is_load_i, ex_rd_wen_i,
           ex_rd_idx_i, ex_md_op_i, id_valid_i, id_rs1_ren_i, id_rs2_ren_i,
           id_rs1_idx_i, id_rs2_idx_i, md_done_i, mem_ready_i,
    input  md_start_o, if_stall_o, id_stall_o, ex_stall_o, id_flush_o,
           ex_flush_o, redirect_o, redirect_pc_o
  );

endinterface

// File: rtl/ex_pipe_ctrl.sv
// rtl/ex_pipe_ctrl.sv - stall/flush/redirect arbitration and mul/div sequencing for the 5-stage core
//
// Purpose : prioritises MEM wait > mul/div wait > EX redirect > load-use,
//           sequences the mul/div start/done handshake and counts IF stall cycles.
// Ports   : clk, rst_n (async, active-low)
//           pipe        - ex_pipe_ctrl_if.slave hazard/control bundle
//           stall_cnt_o - saturating count of cycles with if_stall_o=1

module ex_pipe_ctrl
  import ex_pipe_ctrl_pkg::*;
#(
  parameter int PC_WIDTH  = PC_WIDTH_DEF,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ex_pipe_ctrl_if.slave        pipe,
  output logic [CNT_WIDTH-1:0] stall_cnt_o
);

  md_state_e            state_q, state_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  logic                mem_stall, md_wait, lu, jump;
  logic                stall_all, stall_front, flush_id, flush_ex, redir, md_start;
  logic [PC_WIDTH-1:0] redir_pc;

  assign mem_stall = !pipe.mem_ready_i;
  assign jump      = pipe.ex_valid_i & pipe.ex_jump_i;

  // MD_DONE deliberately contributes nothing: the result is parked and only
  // the MEM wait keeps the pipe frozen.
  assign md_wait = ((state_q == ST_RUN) & pipe.ex_valid_i & pipe.ex_md_op_i) |
                   ((state_q == ST_MD_BUSY) & !pipe.md_done_i);

  assign lu = pipe.ex_valid_i & pipe.ex_is_load_i & pipe.ex_rd_wen_i &
              (pipe.ex_rd_idx_i != '0) & pipe.id_valid_i &
              ((pipe.id_rs1_ren_i & (pipe.id_rs1_idx_i == pipe.ex_rd_idx_i)) |
               (pipe.id_rs2_ren_i & (pipe.id_rs2_idx_i == pipe.ex_rd_idx_i)));

  always_comb begin
    stall_all   = 1'b0;
    stall_front = 1'b0;
    flush_id    = 1'b0;
    flush_ex    = 1'b0;
    redir       = 1'b0;
    redir_pc    = '0;
    md_start    = 1'b0;
    if (mem_stall) begin
      stall_all = 1'b1;
    end else if (md_wait) begin
      stall_all = 1'b1;
      // Only the RUN leg of md_wait is a fresh issue; MD_BUSY never re-starts.
      md_start  = (state_q == ST_RUN);
    end else if (jump) begin
      // A jump held in EX by an earlier stall lands here on the first free cycle.
      redir    = 1'b1;
      redir_pc = pipe.ex_jump_pc_i;
      flush_id = 1'b1;
      flush_ex = 1'b1;
    end else if (lu) begin
      stall_front = 1'b1;
      flush_ex    = 1'b1;
    end
  end

  assign pipe.if_stall_o    = stall_all | stall_front;
  assign pipe.id_stall_o    = stall_all | stall_front;
  assign pipe.ex_stall_o    = stall_all;
  assign pipe.id_flush_o    = flush_id;
  assign pipe.ex_flush_o    = flush_ex;
  assign pipe.redirect_o    = redir;
  assign pipe.redirect_pc_o = redir_pc;
  assign pipe.md_start_o    = md_start;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (pipe.ex_valid_i & pipe.ex_md_op_i & !mem_stall) state_d = ST_MD_BUSY;
      end
      ST_MD_BUSY: begin
        if (pipe.md_done_i) state_d = mem_stall ? ST_MD_DONE : ST_RUN;
      end
      ST_MD_DONE: begin
        if (!mem_stall) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (pipe.if_stall_o && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: doc/ex_pipe_ctrl.md
Name: ex_pipe_ctrl

Overview:
Pipeline control unit for the 5-stage core. It arbitrates the stall and flush requests that come from the EX stage, the ID stage and the MEM stage:
- EX-stage branch/jal/jalr redirect
- ID/EX load-use hazard
- multi-cycle mul/div unit attached to EX
- MEM-stage data wait

It sequences the mul/div handshake with a small FSM, drives per-stage stall/flush and the fetch redirect, and keeps a saturating stall-cycle counter.

Parameters:
PC_WIDTH, 32, width of jump target / redirect PC
CNT_WIDTH, 32, width of stall-cycle performance counter

Ports:
clk  in  1  core clock
rst_n  in  1  reset, asynchronous, active-low
ex_valid_i  in  1  EX holds a valid instruction
ex_jump_i  in  1  EX resolved jump taken (branch/jal/jalr)
ex_jump_pc_i  in  PC_WIDTH  jump target from EX
ex_is_load_i  in  1  EX instruction is a load
ex_rd_wen_i  in  1  EX instruction writes rd
ex_rd_idx_i  in  5  EX destination register
ex_md_op_i  in  1  EX instruction is mul/div
id_valid_i  in  1  ID holds a valid instruction
id_rs1_ren_i  in  1  ID reads rs1
id_rs2_ren_i  in  1  ID reads rs2
id_rs1_idx_i  in  5  ID rs1 index
id_rs2_idx_i  in  5  ID rs2 index
md_start_o  out  1  one-cycle start pulse to mul/div unit
md_done_i  in  1  mul/div result valid (level, held until consumed)
mem_ready_i  in  1  MEM stage can advance (0 = memory wait)
if_stall_o  out  1  hold PC/IF register
id_stall_o  out  1  hold IF/ID register
ex_stall_o  out  1  hold ID/EX register and EX
id_flush_o  out  1  load bubble into IF/ID
ex_flush_o  out  1  load bubble into ID/EX
redirect_o  out  1  fetch redirect
redirect_pc_o  out  PC_WIDTH  redirect target
stall_cnt_o  out  CNT_WIDTH  cycles with if_stall_o=1, saturating

Behaviour:
- Reset: rst_n low asynchronously forces FSM=RUN and stall_cnt_o=0. All comb outputs are then 0 given idle inputs. redirect_pc_o=0 when redirect_o=0.
- Signals:
  - mem_stall = !mem_ready_i
  - md_wait = (state==RUN & ex_valid_i & ex_md_op_i) | (state==MD_BUSY & !md_done_i)
  - lu = ex_valid_i & ex_is_load_i & ex_rd_wen_i & ex_rd_idx_i!=0 & id_valid_i & ((id_rs1_ren_i & id_rs1_idx_i==ex_rd_idx_i) | (id_rs2_ren_i & id_rs2_idx_i==ex_rd_idx_i))
- Priority, highest first:
  1. mem_stall: if/id/ex stall=1, no flush, no redirect, no md_start.
  2. md_wait: if/id/ex stall=1, no flush, no redirect.
  3. ex_valid_i & ex_jump_i: redirect_o=1, redirect_pc_o=ex_jump_pc_i, id_flush_o=1, ex_flush_o=1, no stall. Load-use is ignored because the ID instruction is squashed.
  4. lu: if_stall_o=id_stall_o=1, ex_flush_o=1 (exactly one bubble). ex_stall_o=0.
  5. Otherwise all 0.
- FSM (RUN, MD_BUSY, MD_DONE):
  - RUN -> MD_BUSY when ex_valid_i & ex_md_op_i & !mem_stall. md_start_o=1 in that cycle only.
  - MD_BUSY stays while !md_done_i. On md_done_i & mem_ready_i -> RUN; stalls drop that cycle so EX advances at the edge. On md_done_i & mem_stall -> MD_DONE.
  - MD_DONE: md_wait=0 (stalls come only from mem_stall). -> RUN when mem_ready_i. Never re-issues md_start_o for the same instruction.
- A jump in EX while a stall is active is deferred: redirect fires in the first unstalled cycle, exactly once.
- stall_cnt_o increments by 1 each cycle if_stall_o=1 and holds at all-ones.
- Reset mid-operation (MD_BUSY) returns to RUN. A late md_done_i while state==RUN with no md op in EX is ignored.

Decomposition:
- Shared package/defines: FSM state encodings (2-bit), PC_WIDTH via the existing `PC_WIDTH define, register index width 5.
- No sub-module is needed. The load-use comparator stays inline.
- Optionally split stall_cnt into a generic sat_counter sub-module if one already exists in the codebase.

Test Plan:
- Reset with rst_n=0 mid-run -> all outputs 0, stall_cnt_o=0, FSM RUN on release.
- EX jal with ex_jump_pc_i=0x80000040, mem_ready_i=1 -> redirect_o=1, redirect_pc_o=0x80000040, id_flush_o=ex_flush_o=1 in that cycle only.
- EX load to x5, ID reads rs2=x5 -> one cycle if/id stall + ex_flush; next cycle clear. The same case with rd=x0 -> no stall.
- EX div, md_done_i after 4 cycles -> md_start_o single pulse, stalls held 4 cycles then released, stall_cnt_o=4.
- md_done_i arrives while mem_ready_i=0 for 2 cycles -> FSM MD_DONE, no second md_start_o, stalls released when mem_ready_i=1.
- Jump in EX while mem_ready_i=0 for 3 cycles -> no redirect for 3 cycles, then exactly one redirect pulse.
